// File: rtl/decoder_3_8_pkg.sv
// Shared types and width constants for the 3:8 decoder slice.
// No ports; imported by the decoder top and its bus interface.
package decoder_3_8_pkg;

    localparam int CODE_W = 3;
    localparam int OUT_W  = 8;
    localparam int SUB_W  = 2;
    localparam int SUB_N  = 4;

    typedef logic [CODE_W-1:0] code_t;
    typedef logic [OUT_W-1:0]  onehot_t;

    // True when at most one bit of v is set.
    function automatic logic is_onehot0(onehot_t v);
        return (v & (v - onehot_t'(1))) == '0;
    endfunction

endpackage

// File: rtl/decoder_3_8_if.sv
// Bus bundle for a 3:8 decoder: code, enable and one-hot result.
// master drives in/e and reads out; slave is the decoder side.
interface decoder_3_8_if;
    import decoder_3_8_pkg::*;

    code_t   in;
    logic    e;
    onehot_t out;

    modport master (
        output in,
        output e,
        input  out
    );

    modport slave (
        input  in,
        input  e,
        output out
    );

endinterface

// File: rtl/decoder_3_8_dec24.sv
// Combinational 2:4 one-hot decoder with active-high enable.
// Ports: out[3:0] one-hot result, in[1:0] code, e enable.
module decoder_2_4 (
    output logic [3:0] out,
    input  logic [1:0] in,
    input  logic       e
);

    always_comb begin
        out = 4'b0000;
        if (e) begin
            unique case (in)
                2'd0:    out = 4'b0001;
                2'd1:    out = 4'b0010;
                2'd2:    out = 4'b0100;
                2'd3:    out = 4'b1000;
                default: out = 4'b0000;
            endcase
        end
    end

endmodule

// File: rtl/decoder_3_8.sv
// 3:8 one-hot decoder built from a 2:4 decoder gated by in[2].
// Ports: out[7:0], in[2:0], e, clk, reset (clk/reset used when REGISTERED=1).
module decoder_3_8
    import decoder_3_8_pkg::*;
#(
    parameter int REGISTERED = 0
) (
    output onehot_t out,
    input  code_t   in,
    input  logic    e,
    input  logic    clk,
    input  logic    reset
);

    logic [SUB_N-1:0] lo;
    onehot_t          dec;

    decoder_2_4 u_dec24 (
        .out (lo),
        .in  (in[SUB_W-1:0]),
        .e   (e)
    );

    // in[2] steers the 2:4 result into the upper or lower nibble.
    assign dec = in[CODE_W-1] ? {lo, 4'b0000} : {4'b0000, lo};

    generate
        if (REGISTERED != 0) begin : g_reg
            onehot_t q;

            always_ff @(posedge clk) begin
                if (reset) q <= '0;
                else       q <= dec;
            end

            assign out = q;
        end else begin : g_comb
            // clk/reset are deliberately inert in combinational mode.
            logic unused_ok;
            assign unused_ok = &{1'b0, clk, reset};
            assign out = dec;
        end
    endgenerate

endmodule

// File: tb/tb_decoder_3_8.sv
// Testbench for decoder_3_8 (both modes), decoder_2_4 and a 5:32 tree.
// No ports; prints one summary line.
module tb_decoder_3_8;
    import decoder_3_8_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    decoder_3_8_if bus ();

    decoder_3_8 #(.REGISTERED(0)) dut (
        .out   (bus.out),
        .in    (bus.in),
        .e     (bus.e),
        .clk   (clk),
        .reset (reset)
    );

    onehot_t rout;
    decoder_3_8 #(.REGISTERED(1)) dut_r (
        .out   (rout),
        .in    (bus.in),
        .e     (bus.e),
        .clk   (clk),
        .reset (reset)
    );

    logic [3:0] s_out;
    logic [1:0] s_in;
    logic       s_e;
    decoder_2_4 u24 (.out(s_out), .in(s_in), .e(s_e));

    logic [4:0]  t_in;
    logic        t_e;
    logic [3:0]  t_en;
    logic [31:0] t_out;
    decoder_2_4 t24 (.out(t_en), .in(t_in[4:3]), .e(t_e));
    for (genvar k = 0; k < 4; k++) begin : g_tree
        decoder_3_8 #(.REGISTERED(0)) t38 (
            .out   (t_out[8*k +: 8]),
            .in    (t_in[2:0]),
            .e     (t_en[k]),
            .clk   (clk),
            .reset (reset)
        );
    end

    typedef struct {
        logic       e;
        logic [2:0] in;
        logic [7:0] exp;
    } vec_t;

    typedef struct {
        logic       e;
        logic [1:0] in;
        logic [3:0] exp;
    } v24_t;

    int total = 0;
    int bad   = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    vec_t vecs [16];
    v24_t v24 [5];

    initial begin
        vecs[0]  = '{1'b0, 3'd0, 8'h00};
        vecs[1]  = '{1'b0, 3'd1, 8'h00};
        vecs[2]  = '{1'b0, 3'd2, 8'h00};
        vecs[3]  = '{1'b0, 3'd3, 8'h00};
        vecs[4]  = '{1'b0, 3'd4, 8'h00};
        vecs[5]  = '{1'b0, 3'd5, 8'h00};
        vecs[6]  = '{1'b0, 3'd6, 8'h00};
        vecs[7]  = '{1'b0, 3'd7, 8'h00};
        vecs[8]  = '{1'b1, 3'd0, 8'h01};
        vecs[9]  = '{1'b1, 3'd1, 8'h02};
        vecs[10] = '{1'b1, 3'd2, 8'h04};
        vecs[11] = '{1'b1, 3'd3, 8'h08};
        vecs[12] = '{1'b1, 3'd4, 8'h10};
        vecs[13] = '{1'b1, 3'd5, 8'h20};
        vecs[14] = '{1'b1, 3'd6, 8'h40};
        vecs[15] = '{1'b1, 3'd7, 8'h80};

        v24[0] = '{1'b1, 2'd0, 4'b0001};
        v24[1] = '{1'b1, 2'd1, 4'b0010};
        v24[2] = '{1'b1, 2'd2, 4'b0100};
        v24[3] = '{1'b1, 2'd3, 4'b1000};
        v24[4] = '{1'b0, 2'd3, 4'b0000};

        reset  = 1'b1;
        bus.e  = 1'b1;
        bus.in = 3'd5;
        s_e = 1'b0; s_in = 2'd0;
        t_e = 1'b0; t_in = 5'd0;

        // Registered reset state; reset overrides an enabled code.
        @(posedge clk); #1;
        chk("reg_reset", {24'd0, rout}, 32'h00);
        // Combinational mode ignores reset.
        chk("comb_reset_ignored", {24'd0, bus.out}, 32'h20);
        @(negedge clk);
        reset = 1'b0;
        bus.e = 1'b0;
        @(posedge clk); #1;
        chk("reg_idle", {24'd0, rout}, 32'h00);

        // Combinational table.
        for (int i = 0; i < 16; i++) begin
            bus.e  = vecs[i].e;
            bus.in = vecs[i].in;
            #1;
            chk($sformatf("comb[%0d]", i), {24'd0, bus.out},
                {24'd0, vecs[i].exp});
            chk($sformatf("comb_1hot[%0d]", i),
                32'($countones(bus.out) <= 1), 32'd1);
        end

        // Registered table: old value before the edge, new after.
        begin
            logic [7:0] prev;
            @(negedge clk);
            bus.e = 1'b0;
            @(posedge clk); #1;
            prev = 8'h00;
            for (int i = 0; i < 16; i++) begin
                @(negedge clk);
                bus.e  = vecs[i].e;
                bus.in = vecs[i].in;
                #1;
                chk($sformatf("reg_hold[%0d]", i), {24'd0, rout},
                    {24'd0, prev});
                @(posedge clk); #1;
                chk($sformatf("reg[%0d]", i), {24'd0, rout},
                    {24'd0, vecs[i].exp});
                prev = vecs[i].exp;
            end
        end

        // Latency and mid-run reset sequence.
        @(negedge clk);
        bus.e = 1'b0; bus.in = 3'd5;
        @(posedge clk); #1;
        chk("seq_off", {24'd0, rout}, 32'h00);
        @(negedge clk);
        bus.e = 1'b1;
        #1;
        chk("seq_before_N", {24'd0, rout}, 32'h00);
        @(posedge clk); #1;
        chk("seq_after_N", {24'd0, rout}, 32'h20);
        @(posedge clk); #1;
        chk("seq_N1", {24'd0, rout}, 32'h20);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("seq_reset_N2", {24'd0, rout}, 32'h00);
        chk("seq_comb_in_reset", {24'd0, bus.out}, 32'h20);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("seq_release_hold", {24'd0, rout}, 32'h00);
        @(posedge clk); #1;
        chk("seq_resume", {24'd0, rout}, 32'h20);

        // Enable and code change together in one cycle.
        @(negedge clk);
        bus.e = 1'b0; bus.in = 3'd7;
        @(posedge clk); #1;
        chk("seq_joint_off", {24'd0, rout}, 32'h00);
        @(negedge clk);
        bus.e = 1'b1; bus.in = 3'd2;
        @(posedge clk); #1;
        chk("seq_joint_on", {24'd0, rout}, 32'h04);

        // 2:4 sub-decoder table.
        for (int i = 0; i < 5; i++) begin
            s_e  = v24[i].e;
            s_in = v24[i].in;
            #1;
            chk($sformatf("d24[%0d]", i), {28'd0, s_out},
                {28'd0, v24[i].exp});
        end

        // 5:32 tree: disabled sweep then enabled sweep.
        for (int en = 0; en < 2; en++) begin
            for (int c = 0; c < 32; c++) begin
                logic [31:0] want;
                t_e  = 1'(en);
                t_in = 5'(c);
                want = en != 0 ? 32'd1 << c : 32'd0;
                #1;
                chk($sformatf("tree[e%0d,%0d]", en, c), t_out, want);
            end
        end
        t_e = 1'b1; t_in = 5'd19;
        #1;
        chk("tree_19", t_out, 32'h0008_0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/decoder_3_8.md
DECODER_3_8 -- requirements
Module: decoder_3_8

Interface
REQ-001 Parameter REGISTERED, default 0: 0 = purely combinational output; 1 = output registered on clk.
REQ-002 clk  input  1  single clock; used only when REGISTERED=1, otherwise ignored.
REQ-003 reset  input  1  synchronous, active-high reset; used only when REGISTERED=1, otherwise ignored.
REQ-004 out  output  8  one-hot decode result; bit i corresponds to code i.
REQ-005 in  input  3  binary code to decode, unsigned.
REQ-006 e  input  1  active-high enable.
REQ-007 Port order SHALL be out, in, e, clk, reset, so positional instances (out,in,e) in existing decoder trees stay valid with clk/reset left unconnected when REGISTERED=0.

Function
REQ-008 With e=1, out SHALL have exactly bit in set and all other bits 0 (out = 1 << in).
REQ-009 With e=0, out SHALL be 8'h00 regardless of in.
REQ-010 REGISTERED=0: out SHALL follow in and e combinationally with zero latency; no storage, no latches.
REQ-011 REGISTERED=1: out SHALL update on each rising clk edge to the REQ-008/REQ-009 decode of in and e sampled at that edge; latency exactly 1 cycle.
REQ-012 Boundary codes: in=3'd0 -> 8'h01, in=3'd7 -> 8'h80 when enabled; no wrap-around or saturation needed (all 8 codes are valid).
REQ-013 Enable and code changing in the same cycle SHALL be decoded together; there is no priority between them.
REQ-014 At most one out bit SHALL ever be 1 (one-hot or all-zero), in both modes.

Reset
REQ-015 REGISTERED=1: reset=1 at a rising clk edge SHALL force out to 8'h00, overriding in and e.
REQ-016 Reset asserted mid-operation SHALL clear out at the next edge; decoding resumes on the first edge with reset=0.
REQ-017 Reset SHALL have no asynchronous effect; out is undefined only before the first clk edge after power-up.
REQ-018 REGISTERED=0: reset SHALL have no effect on out.

Structure
REQ-019 decoder_3_8 SHALL be built from one sub-module decoder_2_4 (ports out[3:0], in[1:0], e; same one-hot/enable rules, combinational) plus gating by in[2], or as a flat decode; either form is acceptable.
REQ-020 decoder_2_4 SHALL be a separately instantiable module so it can drive enables of four decoder_3_8 instances in a 5:32 decode tree (in[4:3] to decoder_2_4, in[2:0] to each decoder_3_8).
REQ-021 No shared package is required; the widths (2, 3, 4, 8) are fixed constants local to each module.

Verification
REQ-022 e=0, in swept 0..7 -> out=8'h00 every step (both modes).
REQ-023 e=1, in swept 0..7 (REGISTERED=0) -> out = 8'h01, 02, 04, 08, 10, 20, 40, 80 in order; check one-hot each step.
REQ-024 decoder_2_4: e=1, in=0..3 -> 4'b0001, 0010, 0100, 1000; e=0, in=3 -> 4'b0000.
REQ-025 REGISTERED=1: e=1, in=5 applied before edge N -> out=8'h20 after edge N, not before; reset=1 at edge N+2 with in=5 held -> out=8'h00 after edge N+2; reset released -> 8'h20 after the next edge.
REQ-026 5:32 tree (decoder_2_4 + four decoder_3_8, REGISTERED=0): e=0 then e=1 with in swept 0..31 -> 32'h0 while e=0, then exactly bit in set (e.g. in=19 -> 32'h0008_0000).
